latch_bank_writer: RTL and testbench

//  Clocked driver for a bank of negative-level latches with active-high async reset.
//  - Accepts write requests over a valid/ready handshake.
//  - Sequences a shared data bus and one active-low gate per entry through setup,

---
 rtl/latch_bank_pkg.sv | 27 ++
 rtl/latch_bank_shadow.sv | 42 ++++
 rtl/latch_bank_writer.sv | 154 +++++++++++++++
 tb/tb_latch_bank_writer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// Shared types and sizing helpers for the latch bank writer.
// The phase counter is sized so it can hold the longest programmed phase.
package latch_bank_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_OPEN,
        ST_HOLD,
        ST_CLEAR
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int phase_cnt_w(input int s, input int o, input int h, input int c);
        return $clog2(max4(s, o, h, c)) + 1;
    endfunction

endpackage

// File: rtl/latch_bank_shadow.sv
// Flop copy of the latch bank contents, so software can read back what was written
// without touching the level-sensitive cells.
module latch_bank_shadow
    import latch_bank_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (clr) begin
            mem <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) mem[i] <= wr_data;
            end
        end
    end

    // Unmatched addresses (>= DEPTH) fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) rd_data = mem[i];
        end
    end

endmodule

// File: rtl/latch_bank_writer.sv
// Sequences writes into a bank of negative-level latches: data setup, gate open, data hold,
// plus bank-wide clear pulses and a shadow copy for readback.
module latch_bank_writer
    import latch_bank_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             WR_ERR,
    input  logic             CLR_REQ,
    output logic             CLR_DONE,
    output logic [WIDTH-1:0] LATCH_D,
    output logic [DEPTH-1:0] LATCH_G,
    output logic             LATCH_R,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             BUSY
);

    localparam int PW = phase_cnt_w(SETUP_CYC, OPEN_CYC, HOLD_CYC, CLR_CYC);

    state_e            state, nxt;
    logic [PW-1:0]     cnt, cnt_nxt;
    logic [AW-1:0]     addr_q;
    logic              addr_ok_q;
    logic              wr_in_range;
    logic              accept;
    logic              clr_start;
    logic              phase_done;
    logic              shadow_we;
    logic [DEPTH-1:0]  gate_nxt;

    assign wr_in_range = (int'(WR_ADDR) < DEPTH);
    assign phase_done  = (cnt == '0);
    assign WR_READY    = (state == ST_IDLE) && !CLR_REQ;
    assign BUSY        = (state != ST_IDLE);
    assign accept      = WR_VALID && WR_READY;
    assign clr_start   = (state == ST_IDLE) && CLR_REQ;
    assign shadow_we   = (state == ST_OPEN) && phase_done && addr_ok_q;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt - PW'(1);
        case (state)
            ST_INIT: begin
                if (phase_done) begin
                    nxt     = ST_IDLE;
                    cnt_nxt = '0;
                end
            end
            ST_IDLE: begin
                cnt_nxt = cnt;
                if (CLR_REQ) begin
                    nxt     = ST_CLEAR;
                    cnt_nxt = PW'(CLR_CYC - 1);
                end else if (WR_VALID) begin
                    nxt     = ST_SETUP;
                    cnt_nxt = PW'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    nxt     = ST_OPEN;
                    cnt_nxt = PW'(OPEN_CYC - 1);
                end
            end
            ST_OPEN: begin
                if (phase_done) begin
                    nxt     = ST_HOLD;
                    cnt_nxt = PW'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    nxt     = ST_IDLE;
                    cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (phase_done) begin
                    nxt     = ST_IDLE;
                    cnt_nxt = '0;
                end
            end
            default: begin
                nxt     = ST_INIT;
                cnt_nxt = PW'(CLR_CYC - 1);
            end
        endcase
    end

    // Gates are decoded from the next state so the registered gate lines up with the state.
    always_comb begin
        gate_nxt = '1;
        if (nxt == ST_OPEN && addr_ok_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q == AW'(i)) gate_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_INIT;
            cnt       <= PW'(CLR_CYC - 1);
            addr_q    <= '0;
            addr_ok_q <= 1'b0;
            LATCH_D   <= '0;
            LATCH_G   <= '1;
            LATCH_R   <= 1'b1;
            WR_ERR    <= 1'b0;
            CLR_DONE  <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            if (accept) begin
                addr_q    <= WR_ADDR;
                addr_ok_q <= wr_in_range;
                LATCH_D   <= WR_DATA;
            end
            LATCH_G  <= gate_nxt;
            LATCH_R  <= (nxt == ST_INIT) || (nxt == ST_CLEAR);
            WR_ERR   <= accept && !wr_in_range;
            CLR_DONE <= (state == ST_CLEAR) && phase_done;
        end
    end

    latch_bank_shadow #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_shadow (
        .clk     (CLK),
        .rst_n   (RESET),
        .wr_en   (shadow_we),
        .wr_addr (addr_q),
        .wr_data (LATCH_D),
        .clr     (clr_start),
        .rd_addr (RD_ADDR),
        .rd_data (RD_DATA)
    );

endmodule

// File: tb/tb_latch_bank_writer.sv
// Scenario bench for latch_bank_writer: an 8-entry bank for the main flows and a 6-entry
// bank for out-of-range addressing; gate pulses are scored against a queue of expected writes.
module tb_latch_bank_writer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET;

    logic       wr_valid, wr_ready, wr_err, clr_req, clr_done, latch_r, busy;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data, latch_d, latch_g, rd_data;

    logic       wr_valid6, wr_ready6, wr_err6, clr_req6, clr_done6, latch_r6, busy6;
    logic [2:0] wr_addr6, rd_addr6;
    logic [7:0] wr_data6, latch_d6, rd_data6;
    logic [5:0] latch_g6;

    latch_bank_writer dut (
        .CLK(CLK), .RESET(RESET), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_ERR(wr_err), .CLR_REQ(clr_req),
        .CLR_DONE(clr_done), .LATCH_D(latch_d), .LATCH_G(latch_g), .LATCH_R(latch_r),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data), .BUSY(busy)
    );

    latch_bank_writer #(.DEPTH(6)) dut6 (
        .CLK(CLK), .RESET(RESET), .WR_VALID(wr_valid6), .WR_READY(wr_ready6),
        .WR_ADDR(wr_addr6), .WR_DATA(wr_data6), .WR_ERR(wr_err6), .CLR_REQ(clr_req6),
        .CLR_DONE(clr_done6), .LATCH_D(latch_d6), .LATCH_G(latch_g6), .LATCH_R(latch_r6),
        .RD_ADDR(rd_addr6), .RD_DATA(rd_data6), .BUSY(busy6)
    );

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  clr_pulses = 0;
    int  err6_pulses = 0;

    // Gate monitor: one-hot-low, never during clear, pulse matches the next expected write.
    initial begin : monitor
        int  nlow, idx, plen;
        bit  in_pulse;
        wr_t e;
        in_pulse = 0;
        plen = 0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                in_pulse = 0;
            end else begin
                if (clr_done) clr_pulses++;
                if (wr_err6) err6_pulses++;
                nlow = 0;
                idx  = -1;
                for (int i = 0; i < 8; i++) begin
                    if (latch_g[i] === 1'b0) begin
                        nlow++;
                        idx = i;
                    end
                end
                if (nlow > 0) begin
                    checks++;
                    if (nlow > 1 || latch_r !== 1'b0) begin
                        errors++;
                        $display("FAIL gate_exclusive: LATCH_G=%h LATCH_R=%b", latch_g, latch_r);
                    end
                end
                if (nlow == 1 && !in_pulse) begin
                    in_pulse = 1;
                    plen = 1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL gate_unexpected: idx=%0d data=%h, no write pending", idx, latch_d);
                    end else begin
                        e = exp_q.pop_front();
                        if (idx != int'(e.addr) || latch_d !== e.data) begin
                            errors++;
                            $display("FAIL gate_target: got idx=%0d data=%h, want idx=%0d data=%h",
                                     idx, latch_d, e.addr, e.data);
                        end
                    end
                end else if (nlow == 1) begin
                    plen++;
                end else if (nlow == 0 && in_pulse) begin
                    in_pulse = 0;
                    checks++;
                    if (plen != 2) begin
                        errors++;
                        $display("FAIL gate_width: got %0d cycles, want 2", plen);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (wr_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: WR_READY=%b after %0d cycles, want 1", tag, wr_ready, n);
        end
    endtask

    task automatic test_reset();
        int c0;
        RESET = 1'b0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; clr_req = 0; rd_addr = '0;
        wr_valid6 = 0; wr_addr6 = '0; wr_data6 = '0; clr_req6 = 0; rd_addr6 = '0;
        repeat (3) tick();
        checks++;
        if (latch_r !== 1'b1 || latch_g !== 8'hFF || latch_d !== 8'h00) begin
            errors++;
            $display("FAIL reset_latch: R=%b G=%h D=%h, want 1 FF 00", latch_r, latch_g, latch_d);
        end
        checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b1 || wr_err !== 1'b0 || clr_done !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: RDY=%b BUSY=%b ERR=%b DONE=%b RD=%h, want 0 1 0 0 00",
                     wr_ready, busy, wr_err, clr_done, rd_data);
        end
        c0 = clr_pulses;
        RESET = 1'b1;
        tick();
        checks++;
        if (latch_r !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_hold: R=%b RDY=%b, want 1 0", latch_r, wr_ready);
        end
        tick();
        checks++;
        if (latch_r !== 1'b0 || wr_ready !== 1'b1 || latch_g !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL init_idle: R=%b RDY=%b G=%h BUSY=%b, want 0 1 FF 0", latch_r, wr_ready, latch_g, busy);
        end
        repeat (3) tick();
        checks++;
        if (clr_pulses != c0) begin
            errors++;
            $display("FAIL init_no_done: CLR_DONE pulses=%0d, want 0", clr_pulses - c0);
        end
    endtask

    task automatic test_write();
        rd_addr = 3'd3;
        wr_addr = 3'd3; wr_data = 8'hA5; wr_valid = 1;
        exp_q.push_back({3'd3, 8'hA5});
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready: got %b, want 1", wr_ready);
        end
        tick();
        wr_valid = 0;
        checks++;
        if (latch_d !== 8'hA5 || latch_g !== 8'hFF || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_setup: D=%h G=%h BUSY=%b, want A5 FF 1", latch_d, latch_g, busy);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (latch_g !== 8'hF7) begin
                errors++;
                $display("FAIL write_open%0d: G=%h, want F7", i, latch_g);
            end
        end
        tick();
        checks++;
        if (latch_g !== 8'hFF || latch_d !== 8'hA5 || rd_data !== 8'hA5 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_hold: G=%h D=%h RD=%h RDY=%b, want FF A5 A5 0", latch_g, latch_d, rd_data, wr_ready);
        end
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_done: RDY=%b, want 1", wr_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        wr_addr = 3'd1; wr_data = 8'h11; wr_valid = 1;
        exp_q.push_back({3'd1, 8'h11});
        tick();
        wr_addr = 3'd6; wr_data = 8'h3C;
        exp_q.push_back({3'd6, 8'h3C});
        n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_spacing: next accept %0d cycles after first, want 5", n + 1);
        end
        tick();
        wr_valid = 0;
        checks++;
        if (latch_d !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_second_d: D=%h, want 3C", latch_d);
        end
        wait_ready("b2b");
        rd_addr = 3'd1;
        #1;
        checks++;
        if (rd_data !== 8'h11) begin
            errors++;
            $display("FAIL b2b_rd1: got %h, want 11", rd_data);
        end
        rd_addr = 3'd6;
        #1;
        checks++;
        if (rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_rd6: got %h, want 3C", rd_data);
        end
    endtask

    task automatic test_clr_vs_write();
        int c0;
        c0 = clr_pulses;
        rd_addr = 3'd3;
        wr_addr = 3'd2; wr_data = 8'h5A; wr_valid = 1; clr_req = 1;
        exp_q.push_back({3'd2, 8'h5A});
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_wins: RDY=%b, want 0", wr_ready);
        end
        tick();
        clr_req = 0;
        checks++;
        if (latch_r !== 1'b1 || busy !== 1'b1 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL clr_entry: R=%b BUSY=%b RD=%h, want 1 1 00", latch_r, busy, rd_data);
        end
        tick();
        checks++;
        if (latch_r !== 1'b1 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL clr_hold: R=%b DONE=%b, want 1 0", latch_r, clr_done);
        end
        tick();
        checks++;
        if (latch_r !== 1'b0 || clr_done !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_done: R=%b DONE=%b RDY=%b, want 0 1 1", latch_r, clr_done, wr_ready);
        end
        tick();
        wr_valid = 0;
        checks++;
        if (clr_done !== 1'b0 || latch_d !== 8'h5A) begin
            errors++;
            $display("FAIL clr_then_write: DONE=%b D=%h, want 0 5A", clr_done, latch_d);
        end
        wait_ready("clr");
        rd_addr = 3'd2;
        #1;
        checks++;
        if (rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL clr_rd2: got %h, want 5A", rd_data);
        end
        rd_addr = 3'd1;
        #1;
        checks++;
        if (rd_data !== 8'h00 || clr_pulses != c0 + 1) begin
            errors++;
            $display("FAIL clr_rd1: RD=%h pulses=%0d, want 00 1", rd_data, clr_pulses - c0);
        end
    endtask

    task automatic test_out_of_range();
        int  e0, n;
        bit  gbad;
        wr_addr6 = 3'd0; wr_data6 = 8'h77; wr_valid6 = 1;
        tick();
        wr_valid6 = 0;
        n = 0;
        while (wr_ready6 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        e0 = err6_pulses;
        wr_addr6 = 3'd7; wr_data6 = 8'hEE; wr_valid6 = 1;
        tick();
        wr_valid6 = 0;
        checks++;
        if (wr_err6 !== 1'b1 || wr_ready6 !== 1'b0) begin
            errors++;
            $display("FAIL oor_err: ERR=%b RDY=%b, want 1 0", wr_err6, wr_ready6);
        end
        gbad = 0;
        for (int i = 0; i < 6; i++) begin
            if (latch_g6 !== 6'h3F) gbad = 1;
            tick();
        end
        checks++;
        if (gbad || err6_pulses != e0 + 1 || wr_ready6 !== 1'b1) begin
            errors++;
            $display("FAIL oor_seq: gate_opened=%b err_pulses=%0d RDY=%b, want 0 1 1",
                     gbad, err6_pulses - e0, wr_ready6);
        end
        rd_addr6 = 3'd0;
        #1;
        checks++;
        if (rd_data6 !== 8'h77) begin
            errors++;
            $display("FAIL oor_rd0: got %h, want 77", rd_data6);
        end
        rd_addr6 = 3'd7;
        #1;
        checks++;
        if (rd_data6 !== 8'h00) begin
            errors++;
            $display("FAIL oor_rd7: got %h, want 00", rd_data6);
        end
    endtask

    task automatic test_reset_mid_open();
        rd_addr = 3'd5;
        wr_addr = 3'd5; wr_data = 8'hC3; wr_valid = 1;
        exp_q.push_back({3'd5, 8'hC3});
        tick();
        wr_valid = 0;
        tick();
        checks++;
        if (latch_g !== 8'hDF) begin
            errors++;
            $display("FAIL rst_open_pre: G=%h, want DF", latch_g);
        end
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if (latch_g !== 8'hFF || latch_r !== 1'b1 || wr_ready !== 1'b0 || latch_d !== 8'h00 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_open_now: G=%h R=%b RDY=%b D=%h RD=%h, want FF 1 0 00 00",
                     latch_g, latch_r, wr_ready, latch_d, rd_data);
        end
        tick();
        tick();
        RESET = 1'b1;
        tick();
        checks++;
        if (latch_r !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_replay_init: R=%b RDY=%b, want 1 0", latch_r, wr_ready);
        end
        tick();
        checks++;
        if (latch_r !== 1'b0 || wr_ready !== 1'b1 || latch_g !== 8'hFF) begin
            errors++;
            $display("FAIL rst_replay_idle: R=%b RDY=%b G=%h, want 0 1 FF", latch_r, wr_ready, latch_g);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_clr_vs_write();
        test_out_of_range();
        test_reset_mid_open();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d writes never gated, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
